// File: rtl/mem_port_arbiter_if.sv
// Request/response bundle between the datapath ports, the arbiter and the shared memory port.
// The slave side is the arbiter; the master side is the datapath plus memory.
interface mem_port_arbiter_if;
  logic        inst_read;
  logic [31:0] inst_addr;
  logic        inst_resp;
  logic [31:0] inst_rdata;

  logic        data_read;
  logic        data_write;
  logic [3:0]  data_mbe;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic        data_resp;
  logic [31:0] data_rdata;

  logic        pmem_read;
  logic        pmem_write;
  logic [31:0] pmem_addr;
  logic [3:0]  pmem_mbe;
  logic [31:0] pmem_wdata;
  logic        pmem_resp;
  logic [31:0] pmem_rdata;

  modport slave (
    input  inst_read, inst_addr,
    input  data_read, data_write, data_mbe, data_addr, data_wdata,
    input  pmem_resp, pmem_rdata,
    output inst_resp, inst_rdata,
    output data_resp, data_rdata,
    output pmem_read, pmem_write, pmem_addr, pmem_mbe, pmem_wdata
  );

  modport master (
    output inst_read, inst_addr,
    output data_read, data_write, data_mbe, data_addr, data_wdata,
    output pmem_resp, pmem_rdata,
    input  inst_resp, inst_rdata,
    input  data_resp, data_rdata,
    input  pmem_read, pmem_write, pmem_addr, pmem_mbe, pmem_wdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and data access.
// Data wins by default; a saturating streak counter bounds how long fetch can wait.
module mem_port_arbiter #(
  parameter int unsigned MAX_D_STREAK = 4
) (
  input  logic             clk,
  input  logic             rst,
  mem_port_arbiter_if.slave bus
);

  localparam logic [3:0] MAX_S = 4'(MAX_D_STREAK);

  typedef enum logic [1:0] {IDLE, GNT_I, GNT_D, DONE} state_e;

  typedef struct packed {
    logic [31:0] addr;
    logic [3:0]  mbe;
    logic [31:0] wdata;
    logic        we;
  } hold_t;

  state_e      state_q;
  logic [3:0]  streak_q, streak_d;
  hold_t       hold_q, hold_d;
  logic        pmem_read_q, pmem_write_q;
  logic        inst_resp_q, data_resp_q;
  logic [31:0] inst_rdata_q, data_rdata_q;
  logic        data_req, gnt_d, gnt_i;

  // Low address bits never reach memory; the port is word-addressed.
  logic unused_addr_lsbs;
  assign unused_addr_lsbs = ^{bus.inst_addr[1:0], bus.data_addr[1:0]};

  always_comb begin
    data_req = bus.data_read | bus.data_write;
    gnt_d    = data_req && !(bus.inst_read && (streak_q == MAX_S));
    gnt_i    = bus.inst_read && !gnt_d;

    // read+write together is illegal and resolves to a write
    hold_d = '0;
    if (gnt_d) begin
      hold_d.addr  = {bus.data_addr[31:2], 2'b00};
      hold_d.we    = bus.data_write;
      hold_d.mbe   = bus.data_write ? bus.data_mbe : 4'hF;
      hold_d.wdata = bus.data_wdata;
    end else if (gnt_i) begin
      hold_d.addr = {bus.inst_addr[31:2], 2'b00};
      hold_d.mbe  = 4'hF;
    end

    streak_d = '0;
    if (gnt_d && bus.inst_read)
      streak_d = (streak_q == MAX_S) ? streak_q : streak_q + 4'd1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      streak_q     <= '0;
      hold_q       <= '0;
      pmem_read_q  <= 1'b0;
      pmem_write_q <= 1'b0;
      inst_resp_q  <= 1'b0;
      data_resp_q  <= 1'b0;
      inst_rdata_q <= '0;
      data_rdata_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (gnt_d || gnt_i) begin
            hold_q       <= hold_d;
            streak_q     <= streak_d;
            pmem_read_q  <= !hold_d.we;
            pmem_write_q <= hold_d.we;
            state_q      <= gnt_d ? GNT_D : GNT_I;
          end
        end
        GNT_I, GNT_D: begin
          if (bus.pmem_resp) begin
            pmem_read_q  <= 1'b0;
            pmem_write_q <= 1'b0;
            state_q      <= DONE;
            if (state_q == GNT_I) begin
              inst_resp_q  <= 1'b1;
              inst_rdata_q <= bus.pmem_rdata;
            end else begin
              data_resp_q  <= 1'b1;
              data_rdata_q <= bus.pmem_rdata;
            end
          end
        end
        // Dead cycle lets the served requester drop or change its request.
        DONE: begin
          inst_resp_q <= 1'b0;
          data_resp_q <= 1'b0;
          state_q     <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.pmem_read  = pmem_read_q;
  assign bus.pmem_write = pmem_write_q;
  assign bus.pmem_addr  = hold_q.addr;
  assign bus.pmem_mbe   = hold_q.mbe;
  assign bus.pmem_wdata = hold_q.wdata;
  assign bus.inst_resp  = inst_resp_q;
  assign bus.inst_rdata = inst_rdata_q;
  assign bus.data_resp  = data_resp_q;
  assign bus.data_rdata = data_rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: latency-configurable memory model, grant log,
// and hand-computed expectations for fetch, store, priority, starvation, stability and reset.
module tb_mem_port_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  mem_port_arbiter_if bus();

  mem_port_arbiter #(.MAX_D_STREAK(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int checks = 0;
  int errors = 0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a == 32'h60) ? 32'h00A00093 : {a[15:0], 16'hBEEF};
  endfunction

  // Memory: responds in the lat-th cycle the strobe is seen (lat=1 is zero latency).
  int lat = 2;
  bit inj = 1'b0;
  int mcnt = 0;
  always @(negedge clk or negedge rst) begin
    if (!rst) begin
      mcnt = 0;
      bus.pmem_resp = 1'b0;
      bus.pmem_rdata = '0;
    end else if (inj) begin
      bus.pmem_resp = 1'b1;
    end else if ((bus.pmem_read || bus.pmem_write) && !bus.pmem_resp) begin
      mcnt++;
      if (mcnt >= lat) begin
        bus.pmem_resp = 1'b1;
        bus.pmem_rdata = mem_word(bus.pmem_addr);
        mcnt = 0;
      end
    end else begin
      bus.pmem_resp = 1'b0;
      mcnt = 0;
    end
  end

  // Monitor: grant log (address at each strobe rise), resp counts, address stability.
  logic [31:0] glog[$];
  int iresp_n = 0, dresp_n = 0, stab_n = 0;
  logic pstb = 1'b0;
  logic [31:0] paddr = '0;
  always @(negedge clk) begin
    if ((bus.pmem_read || bus.pmem_write) && !pstb) glog.push_back(bus.pmem_addr);
    if ((bus.pmem_read || bus.pmem_write) && pstb && (bus.pmem_addr !== paddr)) stab_n++;
    if (bus.inst_resp === 1'b1) iresp_n++;
    if (bus.data_resp === 1'b1) dresp_n++;
    pstb  = (bus.pmem_read === 1'b1) || (bus.pmem_write === 1'b1);
    paddr = bus.pmem_addr;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // which: 0 inst_resp, 1 data_resp, 2 any strobe; n = negedges waited
  task automatic wait_for(input int which, input string tag, output int n);
    logic hit;
    n = 0;
    hit = 1'b0;
    while (hit !== 1'b1 && n < 64) begin
      @(negedge clk);
      n++;
      case (which)
        0:       hit = bus.inst_resp;
        1:       hit = bus.data_resp;
        default: hit = bus.pmem_read | bus.pmem_write;
      endcase
    end
    chk(tag, {31'd0, hit}, 32'd1);
  endtask

  logic [31:0] sexp [10] = '{32'h200, 32'h204, 32'h208, 32'h20C, 32'hC0,
                             32'h210, 32'h214, 32'h218, 32'h21C, 32'hC4};

  initial begin
    int n, n2, nresp, d0, i0, s0;
    bus.inst_read = 0; bus.inst_addr = '0;
    bus.data_read = 0; bus.data_write = 0; bus.data_mbe = '0;
    bus.data_addr = '0; bus.data_wdata = '0;

    // reset state
    repeat (2) @(negedge clk);
    chk("rst_pmem_read",  {31'd0, bus.pmem_read}, 32'd0);
    chk("rst_pmem_write", {31'd0, bus.pmem_write}, 32'd0);
    chk("rst_inst_resp",  {31'd0, bus.inst_resp}, 32'd0);
    chk("rst_data_resp",  {31'd0, bus.data_resp}, 32'd0);
    chk("rst_pmem_addr",  bus.pmem_addr, 32'd0);
    chk("rst_data_rdata", bus.data_rdata, 32'd0);
    rst = 1'b1;
    @(negedge clk);

    // single fetch
    lat = 2; d0 = dresp_n;
    bus.inst_read = 1; bus.inst_addr = 32'h60;
    wait_for(2, "fetch_strobe", n);
    chk("fetch_pmem_read",  {31'd0, bus.pmem_read}, 32'd1);
    chk("fetch_pmem_write", {31'd0, bus.pmem_write}, 32'd0);
    chk("fetch_pmem_addr",  bus.pmem_addr, 32'h60);
    chk("fetch_pmem_mbe",   {28'd0, bus.pmem_mbe}, 32'hF);
    wait_for(0, "fetch_resp", n);
    chk("fetch_rdata", bus.inst_rdata, 32'h00A00093);
    bus.inst_read = 0;
    @(negedge clk);
    chk("fetch_resp_pulse", {31'd0, bus.inst_resp}, 32'd0);
    chk("fetch_no_data_resp", dresp_n, d0);

    // store
    i0 = iresp_n; d0 = dresp_n;
    bus.data_write = 1; bus.data_addr = 32'h103; bus.data_mbe = 4'b1000; bus.data_wdata = 32'hAB000000;
    wait_for(2, "store_strobe", n);
    chk("store_pmem_write", {31'd0, bus.pmem_write}, 32'd1);
    chk("store_pmem_read",  {31'd0, bus.pmem_read}, 32'd0);
    chk("store_pmem_addr",  bus.pmem_addr, 32'h100);
    chk("store_pmem_mbe",   {28'd0, bus.pmem_mbe}, 32'h8);
    chk("store_pmem_wdata", bus.pmem_wdata, 32'hAB000000);
    wait_for(1, "store_resp", n);
    chk("store_rdata", bus.data_rdata, 32'h0100BEEF);
    bus.data_write = 0;
    @(negedge clk);
    chk("store_resp_count", dresp_n - d0, 1);
    chk("store_no_inst_resp", iresp_n, i0);

    // read+write together resolves to a write
    bus.data_read = 1; bus.data_write = 1; bus.data_addr = 32'h187; bus.data_mbe = 4'b0011;
    bus.data_wdata = 32'h00001234;
    wait_for(2, "rw_strobe", n);
    chk("rw_pmem_write", {31'd0, bus.pmem_write}, 32'd1);
    chk("rw_pmem_read",  {31'd0, bus.pmem_read}, 32'd0);
    chk("rw_pmem_addr",  bus.pmem_addr, 32'h184);
    chk("rw_pmem_mbe",   {28'd0, bus.pmem_mbe}, 32'h3);
    wait_for(1, "rw_resp", n);
    bus.data_read = 0; bus.data_write = 0;
    @(negedge clk);

    // simultaneous: data first, inst latency(1)+3 cycles later
    lat = 2;
    bus.inst_read = 1; bus.inst_addr = 32'h80;
    bus.data_read = 1; bus.data_addr = 32'h140;
    wait_for(2, "sim_strobe", n);
    chk("sim_first_addr", bus.pmem_addr, 32'h140);
    chk("sim_first_mbe", {28'd0, bus.pmem_mbe}, 32'hF);
    wait_for(1, "sim_data_resp", n);
    bus.data_read = 0;
    wait_for(0, "sim_inst_resp", n2);
    chk("sim_turnaround", n2, 4);
    chk("sim_inst_rdata", bus.inst_rdata, 32'h0080BEEF);
    bus.inst_read = 0;
    @(negedge clk);

    // starvation guard: 4 data grants, 1 inst grant, streak restarts
    glog.delete(); lat = 1; nresp = 0;
    bus.inst_addr = 32'hC0; bus.data_addr = 32'h200;
    bus.inst_read = 1; bus.data_read = 1;
    for (int c = 0; c < 300 && nresp < 10; c++) begin
      @(negedge clk);
      if (bus.data_resp) begin nresp++; bus.data_addr += 4; end
      if (bus.inst_resp) begin nresp++; bus.inst_addr += 4; end
      if (nresp == 10) begin bus.inst_read = 0; bus.data_read = 0; end
    end
    chk("starve_nresp", nresp, 10);
    chk("starve_ngrant", glog.size(), 10);
    for (int i = 0; i < 10; i++)
      chk($sformatf("starve_grant%0d", i), (i < glog.size()) ? glog[i] : 32'hxxxxxxxx, sexp[i]);
    @(negedge clk);

    // pmem_resp outside a grant is ignored
    i0 = iresp_n; d0 = dresp_n;
    inj = 1;
    repeat (3) @(negedge clk);
    inj = 0;
    repeat (3) @(negedge clk);
    chk("inj_no_inst_resp", iresp_n, i0);
    chk("inj_no_data_resp", dresp_n, d0);
    chk("inj_no_strobe", {31'd0, bus.pmem_read | bus.pmem_write}, 32'd0);

    // hold registers keep pmem_addr stable while inputs change
    lat = 4; s0 = stab_n;
    bus.data_read = 1; bus.data_addr = 32'h200;
    wait_for(2, "stab_strobe", n);
    bus.data_addr = 32'h300;
    repeat (2) @(negedge clk);
    chk("stab_mid_addr", bus.pmem_addr, 32'h200);
    chk("stab_mid_read", {31'd0, bus.pmem_read}, 32'd1);
    wait_for(1, "stab_resp", n);
    bus.data_read = 0;
    chk("stab_rdata", bus.data_rdata, 32'h0200BEEF);
    chk("stab_no_change", stab_n, s0);
    @(negedge clk);

    // async reset mid-transaction
    lat = 8;
    bus.data_read = 1; bus.data_addr = 32'h240;
    wait_for(2, "rstop_strobe", n);
    #2 rst = 1'b0;
    #1;
    chk("rstop_pmem_read",  {31'd0, bus.pmem_read}, 32'd0);
    chk("rstop_pmem_write", {31'd0, bus.pmem_write}, 32'd0);
    chk("rstop_pmem_addr",  bus.pmem_addr, 32'd0);
    chk("rstop_pmem_mbe",   {28'd0, bus.pmem_mbe}, 32'd0);
    chk("rstop_inst_rdata", bus.inst_rdata, 32'd0);
    chk("rstop_data_rdata", bus.data_rdata, 32'd0);
    chk("rstop_data_resp",  {31'd0, bus.data_resp}, 32'd0);
    bus.data_read = 0;
    @(negedge clk);
    rst = 1'b1;
    lat = 2;
    @(negedge clk);
    bus.inst_read = 1; bus.inst_addr = 32'h60;
    wait_for(2, "post_rst_strobe", n);
    chk("post_rst_addr", bus.pmem_addr, 32'h60);
    chk("post_rst_read", {31'd0, bus.pmem_read}, 32'd1);
    wait_for(0, "post_rst_resp", n);
    chk("post_rst_rdata", bus.inst_rdata, 32'h00A00093);
    bus.inst_read = 0;
    repeat (2) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Arbitrates the pipeline's instruction-fetch port and data-access port onto a single shared memory port. Sits between the five-stage datapath (`inst_read/inst_resp`, `data_read/data_write/data_resp`) and the physical memory (or unified cache). Data requests win by default so MEM-stage stalls clear quickly. A streak counter guarantees instruction fetch cannot be starved.

## Interface
Parameters:
- `MAX_D_STREAK`, default 4: consecutive data grants allowed while an inst request waits; range 1..15.

Ports:
- `clk`  in  1  clock, all state on rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `inst_read`  in  1  fetch request; held until `inst_resp`.
- `inst_addr`  in  32  fetch byte address.
- `inst_resp`  out  1  one-cycle pulse; `inst_rdata` valid.
- `inst_rdata`  out  32  fetched word.
- `data_read`  in  1  load request; held until `data_resp`.
- `data_write`  in  1  store request; held until `data_resp`.
- `data_mbe`  in  4  store byte enables.
- `data_addr`  in  32  data byte address.
- `data_wdata`  in  32  store data.
- `data_resp`  out  1  one-cycle pulse; load data valid or store done.
- `data_rdata`  out  32  loaded word.
- `pmem_read`  out  1  memory read strobe, held until `pmem_resp`.
- `pmem_write`  out  1  memory write strobe, held until `pmem_resp`.
- `pmem_addr`  out  32  word-aligned address `{addr[31:2],2'b00}`.
- `pmem_mbe`  out  4  byte enables: 4'b1111 for reads, `data_mbe` for writes.
- `pmem_wdata`  out  32  store data.
- `pmem_resp`  in  1  memory completion pulse.
- `pmem_rdata`  in  32  memory read data, valid with `pmem_resp`.

## Operation
- States: IDLE, GNT_I, GNT_D, DONE.
- IDLE transitions:
  - No request: stay in IDLE.
  - Only inst: go to GNT_I.
  - Only data: go to GNT_D.
  - Both pending: go to GNT_D unless `streak == MAX_D_STREAK`, then GNT_I.
- Grant entry registers the winner's addr, mbe, wdata and read/write kind into hold registers. `pmem_*` are driven from hold registers only, so they stay stable even if requester inputs change.
- `data_read` and `data_write` both high is illegal. The arbiter treats it as a write.
- GNT_I / GNT_D behaviour:
  - Hold strobes until `pmem_resp`.
  - On `pmem_resp`, pulse the owner's `*_resp` for one cycle with `*_rdata = pmem_rdata`, drop strobes, go to DONE.
- DONE: one dead cycle with no grant, so the served requester can deaster or change its request. Then go to IDLE.
- Streak counter (4 bits):
  - On a GNT_D entry while `inst_read` is high: increment, saturating at MAX_D_STREAK.
  - On any GNT_I entry: clear to 0.
  - On a GNT_D entry with `inst_read` low: clear to 0.
- `*_rdata` holds its last value when no resp is pulsing. The non-owner's resp is never asserted.
- Reset (async, any state, including mid-transaction):
  - State goes to IDLE, streak to 0, hold registers to 0.
  - All strobes and resps go to 0; rdata outputs go to 0.
  - An in-flight memory transaction is abandoned. Memory must be reset with the same `rst`.

## Timing
- Outputs are registered; there is no combinational path from request inputs to `pmem_*`.
- A request sampled in IDLE at edge N produces `pmem_read`/`pmem_write` high from N+1.
- `pmem_resp` sampled at edge M gives:
  - `*_resp` high during cycle M+1 only.
  - Strobes low from M+1.
  - DONE in M+1, IDLE in M+2.
- Earliest next grant is edge M+2; the next `pmem_*` strobe appears at M+3.
- Minimum turnaround is 3 cycles of overhead on top of memory latency.
- Zero-latency memory (resp in the first strobe cycle) is legal and yields the same sequence.
- `pmem_resp` while in IDLE or DONE is ignored.

## Test plan
- Single fetch: `inst_read=1`, `inst_addr=0x60` at edge 0; memory responds 2 cycles later with `0x00A00093`.
  - `pmem_read=1` from edge 1 with `pmem_addr=0x60`, `pmem_mbe=4'hF`.
  - `inst_resp` is a single pulse, `inst_rdata=0x00A00093`, `data_resp` stays 0.
- Store path: `data_write=1`, `data_addr=0x103`, `data_mbe=4'b1000`, `data_wdata=0xAB000000`.
  - `pmem_write=1`, `pmem_addr=0x100`, `pmem_mbe=4'b1000`, `pmem_wdata=0xAB000000`.
  - One `data_resp`, no `pmem_read`.
- Simultaneous request: `inst_read` and `data_read` rise together.
  - Data is served first; inst is granted at the IDLE right after data's DONE.
  - `inst_resp` follows `data_resp` by memory latency + 3 cycles.
- Starvation: `MAX_D_STREAK=4`, `inst_read` held high, data re-requests every IDLE.
  - Exactly 4 data grants, then 1 inst grant, then the streak restarts at 0.
- Stability: change `data_addr` from 0x200 to 0x300 mid-grant.
  - `pmem_addr` remains 0x200 until `pmem_resp`.
- Reset mid-op: drive `rst=0` asynchronously while in GNT_D with `pmem_read=1`.
  - All outputs read 0 before the next clock edge.
  - After release, an inst-only request is granted normally with streak 0.
